// File: rtl/plot_pkg.sv
// ============================================================================
// Module  : plot_pkg
// Brief   : Shared screen geometry, pixel field widths and arbiter state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package plot_pkg;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 15;

    localparam logic [X_W-1:0] SCR_W = 9'd320;
    localparam logic [Y_W-1:0] SCR_H = 8'd240;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } plot_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; search starts just after 'last'.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] w_idx;
        win   = '0;
        any   = 1'b0;
        w_idx = '0;
        // Visit last+1 .. last+N so the previous winner is considered last.
        for (int k = 1; k <= N; k++) begin
            w_idx = IDX_W'((int'(last) + k) % N);
            if (!any && req[w_idx]) begin
                win[w_idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/plot_arbiter.sv
// ============================================================================
// Module  : plot_arbiter
// Brief   : Burst arbiter sharing the vga_adapter pixel port among engines.
//           Optional PLOT_ARB_CLIP_EN drops off-screen pixels and counts them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_arbiter
    import plot_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       pix_valid,
    input  logic [N_REQ-1:0]       pix_last,
    input  logic [N_REQ*X_W-1:0]   pix_x,
    input  logic [N_REQ*Y_W-1:0]   pix_y,
    input  logic [N_REQ*COL_W-1:0] pix_colour,
    output logic [N_REQ-1:0]       gnt,
    output logic                   writeEn,
    output logic [X_W-1:0]         X,
    output logic [Y_W-1:0]         Y,
    output logic [COL_W-1:0]       colour,
    output logic                   busy
`ifdef PLOT_ARB_CLIP_EN
    ,
    output logic [15:0]            clip_count
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    plot_state_t        r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_last;
    logic [15:0]        r_burst_cnt;
    logic               r_busy;
    logic               r_we;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COL_W-1:0]   r_col;
`ifdef PLOT_ARB_CLIP_EN
    logic [15:0]        r_clip_cnt;
`endif

    logic [X_W-1:0]     w_x_arr   [N_REQ];
    logic [Y_W-1:0]     w_y_arr   [N_REQ];
    logic [COL_W-1:0]   w_col_arr [N_REQ];
    logic [N_REQ-1:0]   w_win;
    logic               w_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_sel_req;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_burst_end;
    logic               w_clip;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_x_arr[gi]   = pix_x[gi*X_W +: X_W];
            assign w_y_arr[gi]   = pix_y[gi*Y_W +: Y_W];
            assign w_col_arr[gi] = pix_colour[gi*COL_W +: COL_W];
        end
    endgenerate

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req),
        .last (r_last),
        .win  (w_win),
        .any  (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) w_win_idx = IDX_W'(i);
        end
    end

    // While granted, r_last is the current winner's index.
    assign w_sel_req   = req[r_last];
    assign w_sel_valid = pix_valid[r_last];
    assign w_sel_last  = pix_last[r_last];
    assign w_burst_end = (MAX_BURST != 0) && (r_burst_cnt == 16'(MAX_BURST - 1));

`ifdef PLOT_ARB_CLIP_EN
    assign w_clip = (w_x_arr[r_last] >= SCR_W) || (w_y_arr[r_last] >= SCR_H);
`else
    assign w_clip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_last      <= IDX_W'(N_REQ - 1);
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_col       <= '0;
`ifdef PLOT_ARB_CLIP_EN
            r_clip_cnt  <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_win;
                        r_last      <= w_win_idx;
                        r_burst_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_sel_req) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_sel_valid) begin
                        if (!w_clip) begin
                            r_we  <= 1'b1;
                            r_x   <= w_x_arr[r_last];
                            r_y   <= w_y_arr[r_last];
                            r_col <= w_col_arr[r_last];
                        end
`ifdef PLOT_ARB_CLIP_EN
                        if (w_clip && (r_clip_cnt != 16'hFFFF)) begin
                            r_clip_cnt <= r_clip_cnt + 16'd1;
                        end
`endif
                        if (r_burst_cnt != 16'hFFFF) begin
                            r_burst_cnt <= r_burst_cnt + 16'd1;
                        end
                        if (w_sel_last || w_burst_end) begin
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign writeEn = r_we;
    assign X       = r_x;
    assign Y       = r_y;
    assign colour  = r_col;
`ifdef PLOT_ARB_CLIP_EN
    assign clip_count = r_clip_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plot_arbiter.sv
// ============================================================================
// Module  : tb_plot_arbiter
// Brief   : Directed self-checking bench; instance a unlimited, b MAX_BURST=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, pix_valid, pix_last;
    logic [35:0] pix_x;
    logic [31:0] pix_y;
    logic [59:0] pix_colour;

    logic [3:0]  gnt_a, gnt_b;
    logic        we_a, we_b, busy_a, busy_b;
    logic [8:0]  x_a, x_b;
    logic [7:0]  y_a, y_b;
    logic [14:0] col_a, col_b;
`ifdef PLOT_ARB_CLIP_EN
    logic [15:0] clip_a, clip_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] rr_exp [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [3:0] mb_gnt [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1};
    logic       mb_we  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    plot_arbiter #(.N_REQ(4), .MAX_BURST(0)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .gnt(gnt_a), .writeEn(we_a), .X(x_a), .Y(y_a), .colour(col_a), .busy(busy_a)
`ifdef PLOT_ARB_CLIP_EN
        , .clip_count(clip_a)
`endif
    );

    plot_arbiter #(.N_REQ(4), .MAX_BURST(4)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .gnt(gnt_b), .writeEn(we_b), .X(x_b), .Y(y_b), .colour(col_b), .busy(busy_b)
`ifdef PLOT_ARB_CLIP_EN
        , .clip_count(clip_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_pix(input int i, input logic v, input logic l,
                           input logic [8:0] x, input logic [7:0] y, input logic [14:0] c);
        pix_valid[i]          = v;
        pix_last[i]           = l;
        pix_x[i*9 +: 9]       = x;
        pix_y[i*8 +: 8]       = y;
        pix_colour[i*15 +: 15] = c;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 4'h0;
        pix_valid = 4'h0;
        pix_last  = 4'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 4'hF; pix_valid = 4'h0; pix_last = 4'h0;
        pix_x = '0; pix_y = '0; pix_colour = '0;

        // Reset held two cycles with every request high
        step(); step();
        check_val("rst_gnt",  32'(gnt_a),  32'h0);
        check_val("rst_we",   32'(we_a),   32'h0);
        check_val("rst_busy", 32'(busy_a), 32'h0);
        check_val("rst_x",    32'(x_a),    32'h0);
        reset = 1'b0;
        step();
        check_val("first_gnt",  32'(gnt_a),  32'h1);
        check_val("first_busy", 32'(busy_a), 32'h1);

        // Single three-pixel burst from requester 2
        do_reset();
        req = 4'b0100;
        step();
        check_val("sb_gnt", 32'(gnt_a), 32'h4);
        check_val("sb_we0", 32'(we_a),  32'h0);
        set_pix(2, 1'b1, 1'b0, 9'd10, 8'd20, 15'h7FFF);
        step();
        check_val("sb_we1",  32'(we_a),  32'h1);
        check_val("sb_x1",   32'(x_a),   32'd10);
        check_val("sb_y1",   32'(y_a),   32'd20);
        check_val("sb_col1", 32'(col_a), 32'h7FFF);
        set_pix(2, 1'b1, 1'b0, 9'd11, 8'd20, 15'h1234);
        step();
        check_val("sb_we2",  32'(we_a),  32'h1);
        check_val("sb_x2",   32'(x_a),   32'd11);
        check_val("sb_col2", 32'(col_a), 32'h1234);
        set_pix(2, 1'b1, 1'b1, 9'd12, 8'd20, 15'h0ABC);
        step();
        check_val("sb_we3",   32'(we_a),   32'h1);
        check_val("sb_x3",    32'(x_a),    32'd12);
        check_val("sb_gnt3",  32'(gnt_a),  32'h0);
        check_val("sb_busy3", 32'(busy_a), 32'h0);
        req = 4'h0; pix_valid = 4'h0; pix_last = 4'h0;
        step();
        check_val("sb_we_off", 32'(we_a), 32'h0);
        check_val("sb_x_hold", 32'(x_a),  32'd12);

        // Round robin with single-pixel bursts
        do_reset();
        req = 4'hF; pix_last = 4'hF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_val($sformatf("rr_gnt%0d", k), 32'(gnt_a), 32'(rr_exp[k]));
            check_val($sformatf("rr_we%0d", k), 32'(we_a),
                      (k > 0 && rr_exp[k-1] != 4'h0) ? 32'h1 : 32'h0);
            pix_valid = rr_exp[k];
        end

        // Burst limit: requester 0 streams, requester 1 waits
        do_reset();
        req = 4'b0011;
        set_pix(0, 1'b1, 1'b0, 9'd100, 8'd1, 15'h0001);
        set_pix(1, 1'b1, 1'b1, 9'd200, 8'd2, 15'h0002);
        for (int k = 0; k < 8; k++) begin
            step();
            check_val($sformatf("mb_gnt%0d", k), 32'(gnt_b), 32'(mb_gnt[k]));
            check_val($sformatf("mb_we%0d", k),  32'(we_b),  32'(mb_we[k]));
            if (k == 4) begin
                check_val("mb_x_r0",    32'(x_b),   32'd100);
                check_val("unlim_hold", 32'(gnt_a), 32'h1);
            end
            if (k == 6) check_val("mb_x_r1", 32'(x_b), 32'd200);
        end

        // Ungranted pixels ignored; winner drops request mid-burst
        do_reset();
        set_pix(3, 1'b1, 1'b0, 9'd99, 8'd9, 15'h0009);
        step();
        check_val("ig_gnt", 32'(gnt_a), 32'h0);
        check_val("ig_we",  32'(we_a),  32'h0);
        req = 4'b0001;
        step();
        check_val("ig_gnt0", 32'(gnt_a), 32'h1);
        check_val("ig_we0",  32'(we_a),  32'h0);
        set_pix(0, 1'b1, 1'b0, 9'd50, 8'd5, 15'h0050);
        step();
        check_val("ig_we1", 32'(we_a), 32'h1);
        check_val("ig_x1",  32'(x_a),  32'd50);
        req = 4'h0;
        set_pix(0, 1'b1, 1'b0, 9'd60, 8'd6, 15'h0060);
        step();
        check_val("drop_we",   32'(we_a),   32'h0);
        check_val("drop_gnt",  32'(gnt_a),  32'h0);
        check_val("drop_x",    32'(x_a),    32'd50);
        check_val("drop_busy", 32'(busy_a), 32'h0);

        // Reset in the middle of a burst
        req = 4'b0100; pix_valid = 4'h0;
        step();
        check_val("mr_gnt", 32'(gnt_a), 32'h4);
        set_pix(2, 1'b1, 1'b0, 9'd7, 8'd7, 15'h0007);
        reset = 1'b1;
        step();
        check_val("mr_gnt0",  32'(gnt_a),  32'h0);
        check_val("mr_we0",   32'(we_a),   32'h0);
        check_val("mr_x0",    32'(x_a),    32'h0);
        check_val("mr_busy0", 32'(busy_a), 32'h0);
        reset = 1'b0;

`ifdef PLOT_ARB_CLIP_EN
        do_reset();
        req = 4'b0001;
        step();
        set_pix(0, 1'b1, 1'b0, 9'd320, 8'd5, 15'h1111);
        step();
        check_val("clip_we",  32'(we_a),   32'h0);
        check_val("clip_cnt", 32'(clip_a), 32'h1);
        set_pix(0, 1'b1, 1'b1, 9'd319, 8'd239, 15'h2222);
        step();
        check_val("edge_we", 32'(we_a),   32'h1);
        check_val("edge_x",  32'(x_a),    32'd319);
        check_val("edge_y",  32'(y_a),    32'd239);
        check_val("edge_cnt", 32'(clip_a), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port of `vga_adapter` (320x240, 15-bit colour) among several drawing engines: background clear, osu circle sprite, approach line, score digits, game-over banner. Each engine requests a burst, is granted exclusive access, and streams pixels. The arbiter registers the winner's pixel onto `X`/`Y`/`colour`/`writeEn`. It sits inside `secondlevel`, between `datapath`-style drawing engines and `vga_adapter`, and replaces direct `writeEn` wiring.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters. Index 0 is the highest priority on the first arbitration after reset.
- `MAX_BURST`, 0: maximum pixels per grant. 0 means unlimited.

Ports:
- `clk` in 1: system clock, CLOCK_50.
- `reset` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester burst request. Level-sensitive.
- `pix_valid` in N_REQ: the requester presents a pixel this cycle.
- `pix_last` in N_REQ: the presented pixel is the final pixel of the burst.
- `pix_x` in N_REQ*9: packed X coordinates. Requester i occupies bits [9i+8:9i].
- `pix_y` in N_REQ*8: packed Y coordinates.
- `pix_colour` in N_REQ*15: packed colours.
- `gnt` in/out: `gnt` is out N_REQ, one-hot or zero. Registered.
- `writeEn` out 1: pixel strobe to `vga_adapter.plot`.
- `X` out 9, `Y` out 8, `colour` out 15: pixel to `vga_adapter`.
- `busy` out 1: high while a grant is held.

## Operation
- States:
  - IDLE: `gnt`=0. If `req`≠0, the arbiter picks a winner round-robin, starting at index `last+1` mod N_REQ. It sets `gnt[win]`, stores `last`=win and clears `burst_cnt`, then goes to GRANT.
  - GRANT: `busy`=1. Only the winner's `pix_*` inputs are observed. Each cycle with `pix_valid[win]`=1 forwards one pixel and increments `burst_cnt`.
- GRANT→IDLE when any of the following holds; `gnt` drops on that same edge:
  - `pix_valid[win]` and `pix_last[win]` are both 1. That pixel is still forwarded.
  - `req[win]`=0. No pixel is forwarded that cycle, even if `pix_valid` is high.
  - `MAX_BURST`≠0 and `burst_cnt` reaches `MAX_BURST`-1 on a valid pixel. That pixel is forwarded. The requester keeps its request and re-arbitrates later.
- `pix_valid` from non-granted requesters is ignored, and those pixels are lost. Engines must stall until they see their own `gnt`.
- A requester must not assume a grant while `busy` is high and `gnt` is not its own.
- `burst_cnt` is 16 bits and saturates; it never wraps.
- If `req` goes to 0 in the same cycle the IDLE pick samples it, there is no grant.
- New requests arriving mid-burst wait. They never preempt the current burst.

## Timing
- Reset values: `gnt`=0, `busy`=0, `writeEn`=0, `X`=0, `Y`=0, `colour`=0, `burst_cnt`=0, state IDLE, `last`=N_REQ-1. Requester 0 therefore wins first.
- Grant latency: `req` sampled in IDLE at edge k gives `gnt` high after edge k+1. The minimum is 1 cycle from `req` to `gnt`.
- Pixel latency: a valid pixel at edge n appears on `X`/`Y`/`colour` with `writeEn`=1 for exactly the cycle after edge n+1. The latency is 1 cycle.
- `writeEn` is 0 on every cycle without a forwarded pixel. `X`/`Y`/`colour` hold their last values.
- There is one mandatory IDLE cycle between consecutive bursts, including back-to-back bursts by the same requester.
- Throughput inside a burst is 1 pixel/cycle.
- Reset mid-burst aborts immediately. The next cycle shows reset values, and the partial burst is not resumed.

## Configuration
- `PLOT_ARB_CLIP_EN` defined: a forwarded pixel with X≥320 or Y≥240 is dropped. `writeEn` stays 0, but the pixel still counts toward `burst_cnt` and `pix_last` termination. A 16-bit saturating output `clip_count` counts the dropped pixels and resets to 0.
- Undefined: every pixel is forwarded unmodified, and there is no `clip_count` port.

## Structure
- Shared package `plot_pkg`:
  - constants `SCR_W`=320, `SCR_H`=240, `X_W`=9, `Y_W`=8, `COL_W`=15;
  - the state type (IDLE, GRANT).
- Sub-module `rr_pick`: a combinational round-robin priority picker. Inputs are `req` and `last`; outputs are one-hot `win` and `any`. It is reusable by the future audio trigger arbiter.

## Test plan
- Reset: assert `reset` for 2 cycles with all `req` high → `gnt`=0 and `writeEn`=0. After release, `gnt`=4'b0001 one cycle after the first IDLE sample.
- Single burst: requester 2 sends 3 valid pixels (10,20,15'h7FFF), (11,20,…) and (12,20,…) with `pix_last` on the third → `writeEn` is high for 3 consecutive cycles with matching X/Y/colour, each 1 cycle late. `gnt` drops after the third pixel and `busy`=0.
- Round-robin: hold `req`=4'b1111 with 1-pixel bursts → grant order 0,1,2,3,0, with one idle cycle between each grant.
- Starvation guard: with `MAX_BURST`=4, requester 0 streams 10 pixels and requester 1 is waiting → requester 0 gets 4 pixels, then requester 1 is granted, then requester 0 resumes.
- Ignored pixels and dropped request: requester 3 pulses `pix_valid` without a grant → no `writeEn`. The winner drops `req` mid-burst with `pix_valid` high → that pixel is not written and `gnt`=0 next cycle.
- With `PLOT_ARB_CLIP_EN`: a pixel at (320,5) → `writeEn` stays 0 and `clip_count`=1. A pixel at (319,239) → written.
